// File: rtl/param_datapath_pkg.sv
// Shared opcodes, control-FSM encoding and constant-register values for param_datapath.
package param_datapath_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SHL = 4'd2;
    localparam logic [3:0] OP_SHR = 4'd3;
    localparam logic [3:0] OP_MOV = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_t;

    // R0 reads as zero; Ri holds 2^(i-1). Callers truncate to their datapath width.
    function automatic logic [63:0] const_value(input int unsigned idx);
        if (idx == 0) begin
            return 64'd0;
        end
        return 64'd1 << (idx - 1);
    endfunction

endpackage

// File: rtl/param_datapath_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, BIT_WIDTH cycles per product.
module param_datapath_mul
    import param_datapath_pkg::*;
#(
    parameter int BIT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] product,
    output logic                 overflow
);

    localparam int CW = $clog2(BIT_WIDTH);

    logic [2*BIT_WIDTH-1:0] acc;
    logic [2*BIT_WIDTH-1:0] mcand;
    logic [2*BIT_WIDTH-1:0] acc_next;
    logic [BIT_WIDTH-1:0]   mplier;
    logic [CW-1:0]          count;
    logic                   running;

    // The final partial product is folded in combinationally so the result is
    // ready on the same edge that retires the last iteration.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = running && (count == CW'(BIT_WIDTH - 1));
    assign product  = acc_next[BIT_WIDTH-1:0];
    assign overflow = |acc_next[2*BIT_WIDTH-1:BIT_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            mcand   <= {{BIT_WIDTH{1'b0}}, a};
            mplier  <= b;
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/param_datapath.sv
// Register-file datapath with single-cycle ALU ops and an optional iterative multiply.
// Build option: define PARAM_DATAPATH_MUL_EN to enable MUL; otherwise MUL is a NOP and busy is 0.
module param_datapath
    import param_datapath_pkg::*;
#(
    parameter int BIT_WIDTH      = 16,
    parameter int NUM_REGS       = 16,
    parameter int NUM_CONST_REGS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        op_valid,
    output logic                        op_ready,
    input  logic [3:0]                  opcode,
    input  logic [$clog2(NUM_REGS)-1:0] reg_a_sel,
    input  logic [$clog2(NUM_REGS)-1:0] reg_b_sel,
    input  logic [$clog2(NUM_REGS)-1:0] dest_reg,
    input  logic                        load_operands,
    input  logic [BIT_WIDTH-1:0]        operand_a_in,
    input  logic [BIT_WIDTH-1:0]        operand_b_in,
    output logic [BIT_WIDTH-1:0]        result_out,
    output logic                        result_valid,
    output logic                        zero_flag,
    output logic                        equal_flag,
    output logic                        greater_flag,
    output logic                        carry_flag,
    output logic                        busy
);

    localparam int RW = $clog2(NUM_REGS);
    localparam int SW = $clog2(BIT_WIDTH);

    logic [BIT_WIDTH-1:0] regs [NUM_REGS];
    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic                 accept;
    logic                 do_load;

    logic [BIT_WIDTH:0]   sum_ext;
    logic [BIT_WIDTH:0]   diff_ext;
    logic [BIT_WIDTH-1:0] alu_result;
    logic                 alu_write;
    logic                 alu_set_result;
    logic                 alu_flags;
    logic                 alu_carry;
    logic                 is_mul;

    logic                 reg_we;
    logic [RW-1:0]        reg_wsel;
    logic [BIT_WIDTH-1:0] reg_wdata;

    assign a        = regs[reg_a_sel];
    assign b        = regs[reg_b_sel];
    assign op_ready = !busy && !load_operands;
    assign accept   = op_valid && op_ready;
    assign do_load  = load_operands && !busy;
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_result     = '0;
        alu_write      = 1'b0;
        alu_set_result = 1'b1;
        alu_flags      = 1'b1;
        alu_carry      = 1'b0;
        is_mul         = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_result = sum_ext[BIT_WIDTH-1:0];
                alu_carry  = sum_ext[BIT_WIDTH];
                alu_write  = 1'b1;
            end
            OP_SUB: begin
                alu_result = diff_ext[BIT_WIDTH-1:0];
                alu_carry  = diff_ext[BIT_WIDTH];
                alu_write  = 1'b1;
            end
            OP_SHL: begin
                alu_result = a << b[SW-1:0];
                alu_write  = 1'b1;
            end
            OP_SHR: begin
                alu_result = a >> b[SW-1:0];
                alu_write  = 1'b1;
            end
            OP_MOV: begin
                alu_result = a;
                alu_write  = 1'b1;
            end
            OP_CMP: begin
                alu_set_result = 1'b0;
            end
`ifdef PARAM_DATAPATH_MUL_EN
            OP_MUL: begin
                is_mul         = 1'b1;
                alu_set_result = 1'b0;
            end
`endif
            default: begin
                alu_flags = 1'b0;
            end
        endcase
    end

`ifdef PARAM_DATAPATH_MUL_EN
    state_t               state;
    state_t               state_next;
    logic                 mul_start;
    logic                 mul_done;
    logic [BIT_WIDTH-1:0] mul_product;
    logic                 mul_overflow;
    logic [RW-1:0]        mul_dest;

    assign mul_start = accept && is_mul;
    assign busy      = (state == ST_MUL_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (mul_start) state_next = ST_MUL_RUN;
            ST_MUL_RUN: if (mul_done)  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_dest <= '0;
        end else if (mul_start) begin
            mul_dest <= dest_reg;
        end
    end

    param_datapath_mul #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product),
        .overflow(mul_overflow)
    );
`else
    assign busy = 1'b0;
`endif

    // Single write port: an accepted ALU op and a multiply writeback never coincide.
    always_comb begin
        reg_we    = accept && alu_write;
        reg_wsel  = dest_reg;
        reg_wdata = alu_result;
`ifdef PARAM_DATAPATH_MUL_EN
        if (mul_done) begin
            reg_we    = 1'b1;
            reg_wsel  = mul_dest;
            reg_wdata = mul_product;
        end
`endif
        if (reg_wsel < RW'(NUM_CONST_REGS)) begin
            reg_we = 1'b0;
        end
    end

    // NOTE: the register file is small, so it is reset like ordinary flops; the
    // constant entries are never written and collapse to tie-offs in synthesis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i < NUM_CONST_REGS) ? BIT_WIDTH'(const_value(i)) : '0;
            end
        end else if (do_load) begin
            regs[NUM_CONST_REGS]     <= operand_a_in;
            regs[NUM_CONST_REGS + 1] <= operand_b_in;
            regs[NUM_CONST_REGS + 2] <= '0;
        end else if (reg_we) begin
            regs[reg_wsel] <= reg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_out   <= '0;
            result_valid <= 1'b0;
            zero_flag    <= 1'b0;
            equal_flag   <= 1'b0;
            greater_flag <= 1'b0;
            carry_flag   <= 1'b0;
        end else begin
            result_valid <= accept && !is_mul;
            if (accept) begin
                if (alu_set_result) begin
                    result_out <= alu_result;
                end
                if (alu_flags) begin
                    zero_flag    <= (b == '0);
                    equal_flag   <= (a == b);
                    greater_flag <= (a > b);
                    carry_flag   <= alu_carry;
                end
            end
`ifdef PARAM_DATAPATH_MUL_EN
            if (mul_done) begin
                result_out   <= mul_product;
                result_valid <= 1'b1;
                carry_flag   <= mul_overflow;
            end
`endif
        end
    end

endmodule

// File: tb/tb_param_datapath.sv
// Directed bench for param_datapath (default parameters) with a per-cycle reference model.
module tb_param_datapath;

    localparam int unsigned MASK = 32'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  opcode = 4'd0;
    logic [3:0]  reg_a_sel = 4'd0;
    logic [3:0]  reg_b_sel = 4'd0;
    logic [3:0]  dest_reg = 4'd0;
    logic        load_operands = 1'b0;
    logic [15:0] operand_a_in = 16'd0;
    logic [15:0] operand_b_in = 16'd0;
    logic [15:0] result_out;
    logic        result_valid;
    logic        zero_flag, equal_flag, greater_flag, carry_flag;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    param_datapath dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .opcode       (opcode),
        .reg_a_sel    (reg_a_sel),
        .reg_b_sel    (reg_b_sel),
        .dest_reg     (dest_reg),
        .load_operands(load_operands),
        .operand_a_in (operand_a_in),
        .operand_b_in (operand_b_in),
        .result_out   (result_out),
        .result_valid (result_valid),
        .zero_flag    (zero_flag),
        .equal_flag   (equal_flag),
        .greater_flag (greater_flag),
        .carry_flag   (carry_flag),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Reference model: architectural state updated once per rising edge.
    int unsigned m_regs [16];
    int unsigned m_result, m_mul_val, m_mul_dest;
    bit          m_valid, m_zero, m_equal, m_greater, m_carry, m_mul_ovf;
    int          m_mul_left;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = (i == 0) ? 0 : ((i < 8) ? (32'd1 << (i - 1)) : 0);
        m_result = 0; m_valid = 0; m_mul_left = 0;
        m_zero = 0; m_equal = 0; m_greater = 0; m_carry = 0;
    endtask

    task automatic model_write(input int unsigned d, input int unsigned v);
        if (d >= 8) m_regs[d] = v & MASK;
    endtask

    task automatic model_flags(input int unsigned a, input int unsigned b, input bit c);
        m_zero = (b == 0); m_equal = (a == b); m_greater = (a > b); m_carry = c;
    endtask

    task automatic model_step();
        int unsigned a, b, s;
        longint unsigned p;
        m_valid = 0;
        if (m_mul_left > 0) begin
            m_mul_left--;
            if (m_mul_left == 0) begin
                model_write(m_mul_dest, m_mul_val);
                m_result = m_mul_val; m_valid = 1; m_carry = m_mul_ovf;
            end
        end else if (load_operands) begin
            m_regs[8] = operand_a_in; m_regs[9] = operand_b_in; m_regs[10] = 0;
        end else if (op_valid) begin
            a = m_regs[reg_a_sel];
            b = m_regs[reg_b_sel];
            m_valid = 1;
            case (opcode)
                4'd0: begin s = a + b; m_result = s & MASK; model_flags(a, b, s > MASK); end
                4'd1: begin m_result = (a - b) & MASK; model_flags(a, b, a < b); end
                4'd2: begin m_result = (a << (b % 16)) & MASK; model_flags(a, b, 0); end
                4'd3: begin m_result = a >> (b % 16); model_flags(a, b, 0); end
                4'd4: begin m_result = a; model_flags(a, b, 0); end
                4'd5: model_flags(a, b, 0);
`ifdef PARAM_DATAPATH_MUL_EN
                4'd8: begin
                    p = longint'(a) * longint'(b);
                    m_mul_val = int'(p & MASK); m_mul_ovf = (p > MASK);
                    m_mul_dest = reg_a_sel == reg_a_sel ? dest_reg : dest_reg;
                    m_mul_left = 16; m_valid = 0;
                    model_flags(a, b, 0);
                end
`endif
                default: m_result = 0;
            endcase
            if (opcode <= 4'd4) model_write(dest_reg, m_result);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (rst_n && check_en) begin
            check("busy", busy, m_mul_left > 0);
            check("op_ready", op_ready, (m_mul_left == 0) && !load_operands);
            check("result_valid", result_valid, m_valid);
            check("result_out", result_out, m_result);
            check("zero_flag", zero_flag, m_zero);
            check("equal_flag", equal_flag, m_equal);
            check("greater_flag", greater_flag, m_greater);
            check("carry_flag", carry_flag, m_carry);
        end
    end

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] opc, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd);
        opcode = opc; reg_a_sel = ra; reg_b_sel = rb; dest_reg = rd; op_valid = 1'b1;
        cycle();
        op_valid = 1'b0;
    endtask

    task automatic load(input logic [15:0] va, input logic [15:0] vb);
        operand_a_in = va; operand_b_in = vb; load_operands = 1'b1;
        cycle();
        load_operands = 1'b0;
    endtask

    task automatic expect_reg(input string name, input logic [3:0] r, input logic [15:0] exp);
        issue(4'd4, r, 4'd0, 4'd0);
        check(name, result_out, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] consts [8];
        int  busy_cycles;
        bit  ready_seen, pulse_seen;
        consts = '{16'd0, 16'd1, 16'd2, 16'd4, 16'd8, 16'd16, 16'd32, 16'd64};

        repeat (3) cycle();
        rst_n = 1'b1;
        check_en = 1'b1;
        check("reset_result", result_out, 16'd0);
        check("reset_valid", result_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_flags", {zero_flag, equal_flag, greater_flag, carry_flag}, 4'b0000);

        for (int i = 0; i < 8; i++) expect_reg($sformatf("const_r%0d", i), 4'(i), consts[i]);
        issue(4'd0, 4'd1, 4'd1, 4'd3);
        expect_reg("const_r3_write_dropped", 4'd3, 16'd4);

        load(16'hFFFF, 16'd1);
        issue(4'd0, 4'd8, 4'd9, 4'd10);
        check("add_wrap_result", result_out, 16'h0000);
        check("add_wrap_carry", carry_flag, 1'b1);
        check("add_wrap_valid", result_valid, 1'b1);

        issue(4'd0, 4'd1, 4'd1, 4'd11);
        issue(4'd2, 4'd11, 4'd1, 4'd12);
        check("b2b_shl_result", result_out, 16'd4);
        expect_reg("b2b_r11", 4'd11, 16'd2);
        expect_reg("b2b_r12", 4'd12, 16'd4);

        opcode = 4'd0; reg_a_sel = 4'd1; reg_b_sel = 4'd1; dest_reg = 4'd12; op_valid = 1'b1;
        load(16'd3, 16'd5);
        op_valid = 1'b0;
        expect_reg("load_priority_r12", 4'd12, 16'd4);
        expect_reg("load_priority_r8", 4'd8, 16'd3);

        issue(4'd1, 4'd8, 4'd9, 4'd13);
        check("sub_borrow_result", result_out, 16'hFFFE);
        check("sub_borrow_carry", carry_flag, 1'b1);
        issue(4'd3, 4'd9, 4'd1, 4'd13);
        check("shr_result", result_out, 16'd2);

        load(16'd1, 16'd17);
        issue(4'd2, 4'd8, 4'd9, 4'd10);
        check("shl_amount_low_bits", result_out, 16'd2);

        load(16'd5, 16'd5);
        issue(4'd5, 4'd8, 4'd9, 4'd11);
        check("cmp_equal", equal_flag, 1'b1);
        check("cmp_greater", greater_flag, 1'b0);
        expect_reg("cmp_no_write", 4'd11, 16'd2);

        load(16'd300, 16'd7);
        issue(4'd8, 4'd8, 4'd9, 4'd11);
`ifdef PARAM_DATAPATH_MUL_EN
        busy_cycles = 0; ready_seen = 1'b0;
        while (busy && busy_cycles < 40) begin
            if (op_ready) ready_seen = 1'b1;
            busy_cycles++;
            cycle();
        end
        check("mul_busy_cycles", busy_cycles, 16);
        check("mul_ready_low", ready_seen, 1'b0);
        check("mul_result", result_out, 16'd2100);
        check("mul_valid", result_valid, 1'b1);
        check("mul_carry", carry_flag, 1'b0);
        expect_reg("mul_dest", 4'd11, 16'd2100);
`else
        check("mul_nop_busy", busy, 1'b0);
        check("mul_nop_result", result_out, 16'd0);
        expect_reg("mul_nop_dest", 4'd11, 16'd2);
`endif

`ifdef PARAM_DATAPATH_MUL_EN
        load(16'd300, 16'd7);
        issue(4'd8, 4'd8, 4'd9, 4'd12);
        repeat (4) cycle();
        check("abort_busy_before", busy, 1'b1);
`else
        repeat (4) cycle();
`endif
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", result_valid, 1'b0);
        cycle();
        rst_n = 1'b1;
        pulse_seen = 1'b0;
        repeat (20) begin
            cycle();
            if (result_valid) pulse_seen = 1'b1;
        end
        check("abort_no_pulse", pulse_seen, 1'b0);
        expect_reg("abort_dest", 4'd12, 16'd0);

        cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_datapath.md
PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, meaning datapath and register width in bits (range 4..64).
REQ-002 SHALL have parameter NUM_REGS, default 16, meaning total register count (power of two, 8..64).
REQ-003 SHALL have parameter NUM_CONST_REGS, default 8, meaning read-only constant registers R0..R(NUM_CONST_REGS-1) (range 2..NUM_REGS-3).
REQ-004 SHALL have port clk  input  1  meaning the single clock; every flop is rising-edge.
REQ-005 SHALL have port rst_n  input  1  meaning the reset; reset is asynchronous and active-low.
REQ-006 SHALL have port op_valid  input  1  meaning an operation is presented.
REQ-007 SHALL have port op_ready  output  1  meaning the block accepts an operation this cycle.
REQ-008 SHALL have port opcode  input  4  meaning the operation code.
REQ-009 SHALL have ports reg_a_sel, reg_b_sel, dest_reg  input  RW=$clog2(NUM_REGS) each  meaning source A, source B and destination register.
REQ-010 SHALL have ports load_operands  input 1, operand_a_in and operand_b_in  input BIT_WIDTH  meaning external operand load.
REQ-011 SHALL have ports result_out  output BIT_WIDTH and result_valid  output 1  meaning registered result and its one-cycle strobe.
REQ-012 SHALL have ports zero_flag, equal_flag, greater_flag, carry_flag  output 1 each  meaning registered status flags.
REQ-013 SHALL have port busy  output 1  meaning a multi-cycle operation is in progress.

Function
REQ-014 Constants SHALL be R0=0 and Ri=2^(i-1) truncated to BIT_WIDTH for 1<=i<NUM_CONST_REGS; writes to them are silently dropped.
REQ-015 Opcodes SHALL be ADD=0, SUB=1, SHL=2, SHR=3 (logical), MOV=4 (A), CMP=5 (flags only, no write), MUL=8; all others are NOP (no write, result 0).
REQ-016 An operation SHALL be accepted on a rising edge where op_valid && op_ready; op_ready = !busy && !load_operands.
REQ-017 Single-cycle ops SHALL update result_out, flags and dest_reg on the accepting edge; result_valid is high exactly the following cycle (latency 1), allowing back-to-back issue every cycle with the next op reading the written value.
REQ-018 Shift amount SHALL be reg_b low $clog2(BIT_WIDTH) bits; ADD/SUB SHALL be modulo 2^BIT_WIDTH, carry_flag = carry-out (ADD) or borrow (SUB), cleared by all other ops.
REQ-019 Flags SHALL be computed on operands A/B of the accepted op: zero=(B==0), equal=(A==B), greater=(A>B unsigned); NOP leaves flags unchanged.
REQ-020 load_operands SHALL, on its edge, write R[NUM_CONST_REGS]=operand_a_in, R[+1]=operand_b_in, R[+2]=0, and has priority over any op (op_ready low that cycle); ignored while busy.
REQ-021 Control FSM SHALL have states IDLE and MUL_RUN; IDLE->MUL_RUN on accepted MUL, MUL_RUN->IDLE after exactly BIT_WIDTH iteration cycles, busy=1 only in MUL_RUN.

Reset
REQ-022 Reset SHALL set constants per REQ-014, all writable registers to 0, result_out=0, result_valid=0, all flags=0, busy=0, FSM=IDLE.
REQ-023 Reset asserted mid-MUL SHALL abort it with no writeback and no result_valid.

Configuration
REQ-024 With macro PARAM_DATAPATH_MUL_EN defined, MUL SHALL be an iterative shift-add of A*B keeping low BIT_WIDTH bits, written to dest_reg and result_out with result_valid one cycle after leaving MUL_RUN; carry_flag=1 if the full product overflowed BIT_WIDTH.
REQ-025 Without PARAM_DATAPATH_MUL_EN, MUL SHALL behave as NOP, MUL_RUN SHALL not be synthesised and busy SHALL be tied 0.

Structure
REQ-026 Opcode localparams, FSM state encoding and a constant-value function SHALL live in package param_datapath_pkg.
REQ-027 The iterative multiplier SHALL be sub-module param_datapath_mul (start, A, B -> done, product, overflow).

Verification
REQ-028 Reset then read R0..R7 via MOV -> 0,1,2,4,8,16,32,64; write to R3 -> R3 still 4.
REQ-029 load_operands A=0xFFFF, B=1; ADD R10<-R8+R9 -> result 0x0000, carry=1, result_valid one cycle later.
REQ-030 Back-to-back ADD R11<-R1+R1 then SHL R12<-R11<<R1 on consecutive cycles -> R11=2, R12=4.
REQ-031 With MUL_EN: load 300,7; MUL -> busy for 16 cycles, op_ready low, result 2100, carry=0; without MUL_EN -> NOP, busy never asserts.
REQ-032 Assert rst_n low at cycle 5 of MUL -> busy=0, result_valid never pulses, dest unchanged (0).
REQ-033 CMP with A=5, B=5 -> equal=1, greater=0, no register written.
